// File: rtl/alu_4_bit.sv
// alu_4_bit: registered 4-bit ALU with a carry/borrow bit and tri-state outputs.
//
// Sixteen operations are selected by a 4-bit opcode. Each one is evaluated in
// 5-bit unsigned arithmetic on zero-extended operands. The 5-bit result
// {carry, result} is captured in ALU_Results on every rising clock edge where
// Enable_In is high. While Enable_In is low the register holds its value and
// both outputs float, so several units can share one bus.
//
// Ports:
//   Clock_In                 rising-edge clock
//   Reset_n_In               asynchronous active-low reset, clears ALU_Results
//   Enable_In                1 = compute and drive outputs, 0 = hold and float
//   ALU_Operation_Select_In  opcode (see alu_op_e)
//   Data_A_In, Data_B_In     unsigned operands
//   Result_Out               ALU_Results[3:0] when enabled, else Z
//   Carry_Out                ALU_Results[4]   when enabled, else Z
module alu_4_bit (
  input  logic       Clock_In,
  input  logic       Reset_n_In,
  input  logic       Enable_In,
  input  logic [3:0] ALU_Operation_Select_In,
  input  logic [3:0] Data_A_In,
  input  logic [3:0] Data_B_In,
  output logic [3:0] Result_Out,
  output logic       Carry_Out
);

  typedef enum logic [3:0] {
    OP_INC  = 4'h0,
    OP_DEC  = 4'h1,
    OP_ADD  = 4'h2,
    OP_SUB  = 4'h3,
    OP_RSUB = 4'h4,
    OP_MUL  = 4'h5,
    OP_DIV  = 4'h6,
    OP_MOD  = 4'h7,
    OP_AND  = 4'h8,
    OP_OR   = 4'h9,
    OP_NOTA = 4'hA,
    OP_NOTB = 4'hB,
    OP_NAND = 4'hC,
    OP_NOR  = 4'hD,
    OP_XOR  = 4'hE,
    OP_XNOR = 4'hF
  } alu_op_e;

  // Debug-visible result register: {carry, result}.
  logic [4:0] ALU_Results;

  alu_op_e    op;
  logic [4:0] a_ext;
  logic [4:0] b_ext;
  logic [4:0] next_result;

  assign op    = alu_op_e'(ALU_Operation_Select_In);
  assign a_ext = {1'b0, Data_A_In};
  assign b_ext = {1'b0, Data_B_In};

  // All arithmetic is 5 bits wide, so subtraction wraps modulo 32. This makes
  // bit 4 a borrow flag. Inversions also set bit 4, because they invert the
  // zero-extended operand. A 5-bit multiply yields the low 5 bits of the
  // full 8-bit product.
  always_comb begin
    next_result = '0;
    unique case (op)
      OP_INC:  next_result = a_ext + 5'd1;
      OP_DEC:  next_result = a_ext - 5'd1;
      OP_ADD:  next_result = a_ext + b_ext;
      OP_SUB:  next_result = a_ext - b_ext;
      OP_RSUB: next_result = b_ext - a_ext;
      OP_MUL:  next_result = a_ext * b_ext;
      OP_DIV:  next_result = (Data_B_In == '0) ? 5'b0_1111 : a_ext / b_ext;
      OP_MOD:  next_result = (Data_B_In == '0) ? a_ext     : a_ext % b_ext;
      OP_AND:  next_result = a_ext & b_ext;
      OP_OR:   next_result = a_ext | b_ext;
      OP_NOTA: next_result = ~a_ext;
      OP_NOTB: next_result = ~b_ext;
      OP_NAND: next_result = ~(a_ext & b_ext);
      OP_NOR:  next_result = ~(a_ext | b_ext);
      OP_XOR:  next_result = a_ext ^ b_ext;
      OP_XNOR: next_result = ~(a_ext ^ b_ext);
      default: next_result = '0;
    endcase
  end

  always_ff @(posedge Clock_In or negedge Reset_n_In) begin
    if (!Reset_n_In) begin
      ALU_Results <= '0;
    end else if (Enable_In) begin
      ALU_Results <= next_result;
    end
  end

  // Output enable is purely combinational, so re-enabling drives the held
  // value immediately, without waiting for a clock edge.
  assign Result_Out = Enable_In ? ALU_Results[3:0] : 'z;
  assign Carry_Out  = Enable_In ? ALU_Results[4]   : 1'bz;

endmodule

// File: tb/tb_alu_4_bit.sv
// Testbench for alu_4_bit. The output nets are pulled high, so a floating
// (tri-stated) output reads as all ones.
module tb_alu_4_bit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] op;
  logic [3:0] a;
  logic [3:0] b;
  tri1  [3:0] res_w;
  tri1        carry_w;

  int   checks   = 0;
  int   failures = 0;
  bit   chk_en   = 1'b0;
  logic [4:0] exp_reg;

  alu_4_bit dut (
    .Clock_In               (clk),
    .Reset_n_In             (rst_n),
    .Enable_In              (en),
    .ALU_Operation_Select_In(op),
    .Data_A_In              (a),
    .Data_B_In              (b),
    .Result_Out             (res_w),
    .Carry_Out              (carry_w)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic reduced modulo 32.
  function automatic logic [4:0] ref_alu(input int o, input int x, input int y);
    int r;
    case (o)
      0:  r = x + 1;
      1:  r = x - 1;
      2:  r = x + y;
      3:  r = x - y;
      4:  r = y - x;
      5:  r = x * y;
      6:  r = (y == 0) ? 15 : x / y;
      7:  r = (y == 0) ? x : x % y;
      8:  r = x & y;
      9:  r = x | y;
      10: r = 31 - x;
      11: r = 31 - y;
      12: r = 31 - (x & y);
      13: r = 31 - (x | y);
      14: r = x ^ y;
      default: r = 31 - (x ^ y);
    endcase
    return 5'(r & 31);
  endfunction

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got C=%b R=%h, required C=%b R=%h at %0t",
               name, act[4], act[3:0], req[4], req[3:0], $time);
    end
  endtask

  // Model of the result register.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)  exp_reg <= 5'd0;
    else if (en) exp_reg <= ref_alu(int'(op), int'(a), int'(b));
  end

  // Per-cycle comparison: a disabled output floats and reads as pulled-high.
  always @(negedge clk) begin
    if (chk_en) check("cycle", {carry_w, res_w}, en ? exp_reg : 5'h1F);
  end

  // Apply a vector just after a falling edge, then check it 20 ns later.
  task automatic vec(input string name, input logic [3:0] o, input logic [3:0] x,
                     input logic [3:0] y, input logic [4:0] want);
    @(negedge clk);
    #2;
    en = 1'b1; op = o; a = x; b = y;
    #20;
    check(name, {carry_w, res_w}, want);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; op = '0; a = '0; b = '0;
    #12;
    check("reset_out", {carry_w, res_w}, 5'h00);
    @(negedge clk);
    #2;
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Literal expectations that also pin the reference model.
    check("model_sub",  ref_alu(3, 3, 9),   5'h1A);
    check("model_div0", ref_alu(6, 7, 0),   5'h0F);
    check("model_mul",  ref_alu(5, 15, 15), 5'h01);

    vec("sub_9_3",  4'h3, 4'h9, 4'h3, 5'h06);
    vec("sub_3_9",  4'h3, 4'h3, 4'h9, 5'h1A);
    vec("rsub_3_9", 4'h4, 4'h3, 4'h9, 5'h06);
    vec("inc_F",    4'h0, 4'hF, 4'h0, 5'h10);
    vec("dec_0",    4'h1, 4'h0, 4'h0, 5'h1F);
    vec("add_F_F",  4'h2, 4'hF, 4'hF, 5'h1E);
    vec("mul_7_5",  4'h5, 4'h7, 4'h5, 5'h03);
    vec("div_D_4",  4'h6, 4'hD, 4'h4, 5'h03);
    vec("mod_D_4",  4'h7, 4'hD, 4'h4, 5'h01);
    vec("div_7_0",  4'h6, 4'h7, 4'h0, 5'h0F);
    vec("mod_7_0",  4'h7, 4'h7, 4'h0, 5'h07);
    vec("and",      4'h8, 4'h5, 4'h3, 5'h01);
    vec("or",       4'h9, 4'h5, 4'h3, 5'h07);
    vec("nota",     4'hA, 4'h5, 4'h3, 5'h1A);
    vec("notb",     4'hB, 4'h5, 4'h3, 5'h1C);
    vec("nand",     4'hC, 4'h5, 4'h3, 5'h1E);
    vec("nor",      4'hD, 4'h5, 4'h3, 5'h18);
    vec("xor",      4'hE, 4'h5, 4'h3, 5'h06);
    vec("xnor",     4'hF, 4'h5, 4'h3, 5'h19);

    // Disable: outputs float while new inputs are ignored.
    @(negedge clk);
    #2;
    en = 1'b0;
    op = 4'($urandom); a = 4'($urandom); b = 4'($urandom);
    #20;
    check("tristate", {carry_w, res_w}, 5'h1F);

    // Re-enable between edges: the held result reappears immediately.
    @(negedge clk);
    #2;
    en = 1'b1; op = 4'h2; a = 4'h4; b = 4'h5;
    #1;
    check("reenable_hold", {carry_w, res_w}, 5'h19);
    #20;
    check("reenable_new", {carry_w, res_w}, 5'h09);

    // Asynchronous reset mid-cycle, observed before the next rising edge.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", {carry_w, res_w}, 5'h00);
    #5;
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      logic [3:0] ro, ra, rb;
      ro = 4'($urandom); ra = 4'($urandom); rb = 4'($urandom);
      vec("random", ro, ra, rb, ref_alu(int'(ro), int'(ra), int'(rb)));
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
